// File: rtl/multi_debounce.sv
// multi_debounce: N-channel input debouncer.
// Each channel has a 2-FF synchroniser, a saturating up/down integrator
// (optionally tick-gated), a hysteresis level output and one-cycle rise/fall
// pulses.
// Optional feature macro: DEBOUNCE_EVT_LATCH_EN (sticky press flags on evt).
module multi_debounce #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 20,
  parameter int unsigned STEP  = 1,
  parameter int unsigned TH_HI = 2**(CNT_W-1),
  parameter int unsigned TH_LO = 2**(CNT_W-2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] evt,
  input  logic [N_CH-1:0] evt_clr
);

  localparam logic [CNT_W:0]   CNT_MAX_X = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]   STEP_X    = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] TH_HI_C   = CNT_W'(TH_HI);
  localparam logic [CNT_W-1:0] TH_LO_C   = CNT_W'(TH_LO);

  logic [N_CH-1:0] ff1;
  logic [N_CH-1:0] ff2;

  // Two-stage synchroniser for all raw inputs, free-running (not tick-gated)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= '0;
      ff2 <= '0;
    end else begin
      ff1 <= din;
      ff2 <= ff1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   dif;
    logic             lvl;
    logic             lvl_next;
    logic             rs;
    logic             fl;

    // Integrator next value: widened add/subtract, then clamp to [0, CNT_MAX]
    always_comb begin
      sum      = {1'b0, cnt} + STEP_X;
      dif      = {1'b0, cnt} - STEP_X;
      cnt_next = cnt;
      if (tick) begin
        if (ff2[i]) begin
          cnt_next = (sum > CNT_MAX_X) ? CNT_MAX_X[CNT_W-1:0] : sum[CNT_W-1:0];
        end else begin
          // a set top bit means the subtraction borrowed (cnt < STEP)
          cnt_next = dif[CNT_W] ? '0 : dif[CNT_W-1:0];
        end
      end
    end

    // Hysteresis: set at or above TH_HI, clear at or below TH_LO, else hold
    always_comb begin
      lvl_next = lvl;
      if (cnt >= TH_HI_C) begin
        lvl_next = 1'b1;
      end else if (cnt <= TH_LO_C) begin
        lvl_next = 1'b0;
      end
    end

    // Channel state: counter, level and edge pulses aligned with level change
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
        rs  <= 1'b0;
        fl  <= 1'b0;
      end else begin
        cnt <= cnt_next;
        lvl <= lvl_next;
        rs  <= lvl_next & ~lvl;
        fl  <= ~lvl_next & lvl;
      end
    end

    assign level[i] = lvl;
    assign rise[i]  = rs;
    assign fall[i]  = fl;

`ifdef DEBOUNCE_EVT_LATCH_EN
    logic ev;

    // Sticky press flag: set by a rise pulse, cleared by evt_clr; set wins
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ev <= 1'b0;
      end else if (rs) begin
        ev <= 1'b1;
      end else if (evt_clr[i]) begin
        ev <= 1'b0;
      end
    end

    assign evt[i] = ev;
`else
    assign evt[i] = 1'b0;
`endif
  end

`ifndef DEBOUNCE_EVT_LATCH_EN
  logic unused_evt_clr;
  assign unused_evt_clr = ^evt_clr;
`endif

endmodule
